// File: rtl/csa_operand_feeder_if.sv
// rtl/csa_operand_feeder_if.sv - operand/result handshake and adder bus for csa_operand_feeder
//
// Purpose: bundles the upstream operand stream, the adder operand/result
// wires and the downstream result stream into one interface.
// Signals:
//   in_valid/in_ready/in_data   upstream 4-bit operand handshake
//   csa_a/csa_b/csa_c           operand slots driven to the adder
//   csa_sum/csa_cout            adder outputs returned to the feeder
//   out_valid/out_ready/result  downstream 6-bit result handshake
//   triple_count                completed triples, wraps 255 -> 0
//   err                         sticky adder mismatch flag
// Modports:
//   slave   the feeder itself
//   master  the surrounding environment (upstream, adder, downstream)

interface csa_operand_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] csa_a;
  logic [3:0] csa_b;
  logic [3:0] csa_c;
  logic [4:0] csa_sum;
  logic       csa_cout;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] result;
  logic [7:0] triple_count;
  logic       err;

  modport slave (
    input  in_valid, in_data, csa_sum, csa_cout, out_ready,
    output in_ready, csa_a, csa_b, csa_c, out_valid, result, triple_count, err
  );

  modport master (
    output in_valid, in_data, csa_sum, csa_cout, out_ready,
    input  in_ready, csa_a, csa_b, csa_c, out_valid, result, triple_count, err
  );
endinterface

// File: rtl/csa_operand_feeder.sv
// rtl/csa_operand_feeder.sv - groups 4-bit operands into triples for the carry save adder
//
// Purpose: collects three operands (LOAD), lets the adder settle for one
// cycle (EVAL) while capturing {csa_cout, csa_sum} and cross-checking it
// against a behavioural sum, then presents the result until taken (HOLD).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  csa_operand_feeder_if.slave (operand stream, adder bus, result stream,
//        triple_count, err)

module csa_operand_feeder (
  input logic                  clk,
  input logic                  rst,
  csa_operand_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] idx;
  logic       accept;
  logic       handoff;
  logic [5:0] adder_out;
  logic [5:0] ref_sum;

  // Handshake qualifiers use the registered state, never the ready/valid
  // outputs, so no combinational path exists from in_valid/out_ready.
  assign accept    = bus.in_valid && (state == LOAD);
  assign handoff   = bus.out_ready && (state == HOLD);
  assign adder_out = {bus.csa_cout, bus.csa_sum};
  assign ref_sum   = {2'b00, bus.csa_a} + {2'b00, bus.csa_b} + {2'b00, bus.csa_c};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept && (idx == 2'd2)) state_next = EVAL;
      EVAL:    state_next = HOLD;
      HOLD:    if (handoff) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == HOLD);
  end

  // Operand slots, result capture, completion counter and mismatch flag.
  // Slots are deliberately left intact after a handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= 2'd0;
      bus.csa_a        <= 4'd0;
      bus.csa_b        <= 4'd0;
      bus.csa_c        <= 4'd0;
      bus.result       <= 6'd0;
      bus.triple_count <= 8'd0;
      bus.err          <= 1'b0;
    end else begin
      if (accept) begin
        case (idx)
          2'd0:    bus.csa_a <= bus.in_data;
          2'd1:    bus.csa_b <= bus.in_data;
          2'd2:    bus.csa_c <= bus.in_data;
          default: ;
        endcase
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      if (state == EVAL) begin
        bus.result <= adder_out;
        if (adder_out != ref_sum) begin
          bus.err <= 1'b1;
        end
      end
      if (handoff) begin
        bus.triple_count <= bus.triple_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_csa_operand_feeder.sv
// tb/tb_csa_operand_feeder.sv - self-checking bench for csa_operand_feeder

module tb_csa_operand_feeder;

  logic clk;
  logic rst;
  logic fault;

  csa_operand_feeder_if bus ();

  csa_operand_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural adder; fault adds one to model a broken adder.
  assign {bus.csa_cout, bus.csa_sum} = {2'b00, bus.csa_a} + {2'b00, bus.csa_b}
                                     + {2'b00, bus.csa_c} + {5'd0, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [5:0] exp_result;
  } vec_t;

  vec_t       vecs[6];
  logic [5:0] sb[$];
  int         n_cmp;
  int         n_fail;
  logic [7:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_csa_a", 32'(bus.csa_a), 0);
    check("rst_csa_b", 32'(bus.csa_b), 0);
    check("rst_csa_c", 32'(bus.csa_c), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_triple_count", 32'(bus.triple_count), 0);
    check("rst_err", 32'(bus.err), 0);
  endtask

  // Offer one operand and wait (bounded) for the accepting edge.
  task automatic push_op(input logic [3:0] d);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready) done = 1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) check("push_op_timeout", 0, 1);
  endtask

  task automatic send_triple(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [5:0] exp);
    push_op(a);
    push_op(b);
    push_op(c);
    sb.push_back(exp);
  endtask

  task automatic wait_out_valid();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.out_valid) seen = 1;
      else tick();
    end
    if (!seen) check("out_valid_timeout", 0, 1);
  endtask

  // Wait for a result, compare against the scoreboard, then hand it off.
  task automatic take_result(input string name);
    logic [5:0] exp;
    wait_out_valid();
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      exp = sb.pop_front();
      check(name, 32'(bus.result), 32'(exp));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_count++;
    check("triple_count", 32'(bus.triple_count), 32'(exp_count));
  endtask

  initial begin
    logic [3:0] ra, rb, rc;
    n_cmp = 0;
    n_fail = 0;
    exp_count = 8'd0;
    fault = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 4'd0;
    bus.out_ready = 1'b0;

    vecs[0] = '{a: 4'd15, b: 4'd15, c: 4'd15, exp_result: 6'b101101};
    vecs[1] = '{a: 4'd0,  b: 4'd0,  c: 4'd0,  exp_result: 6'd0};
    vecs[2] = '{a: 4'd1,  b: 4'd2,  c: 4'd3,  exp_result: 6'd6};
    vecs[3] = '{a: 4'd7,  b: 4'd8,  c: 4'd9,  exp_result: 6'd24};
    vecs[4] = '{a: 4'd10, b: 4'd0,  c: 4'd5,  exp_result: 6'd15};
    vecs[5] = '{a: 4'd15, b: 4'd0,  c: 4'd15, exp_result: 6'd30};

    do_reset();
    check_reset_state();

    // Triple 1,1,1 with continuous in_valid and out_ready high.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 4'd1;
    tick();
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("t1_in_ready_drop", 32'(bus.in_ready), 0);
    check("t1_eval_no_valid", 32'(bus.out_valid), 0);
    tick();
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_result", 32'(bus.result), 6'b000011);
    check("t1_err", 32'(bus.err), 0);
    tick();
    exp_count = 8'd1;
    check("t1_triple_count", 32'(bus.triple_count), 32'(exp_count));
    check("t1_in_ready_back", 32'(bus.in_ready), 1);
    check("t1_out_valid_low", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Table-driven triples.
    for (int i = 0; i < 6; i++) begin
      send_triple(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_result);
      wait_out_valid();
      check("tbl_csa_a", 32'(bus.csa_a), 32'(vecs[i].a));
      check("tbl_csa_b", 32'(bus.csa_b), 32'(vecs[i].b));
      check("tbl_csa_c", 32'(bus.csa_c), 32'(vecs[i].c));
      take_result("tbl_result");
      check("tbl_err", 32'(bus.err), 0);
    end

    // Backpressure on 5,9,2 with ignored in_valid pulses.
    send_triple(4'd5, 4'd9, 4'd2, 6'b010000);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data = 4'hA;
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_result", 32'(bus.result), 6'b010000);
    end
    bus.in_valid = 1'b0;
    check("bp_csa_a", 32'(bus.csa_a), 5);
    check("bp_csa_b", 32'(bus.csa_b), 9);
    check("bp_csa_c", 32'(bus.csa_c), 2);
    check("bp_count_stalled", 32'(bus.triple_count), 32'(exp_count));
    take_result("bp_result_taken");
    check("bp_single_handshake", 32'(bus.out_valid), 0);

    // Gapped input 3, 7, 8.
    push_op(4'd3);
    repeat (4) tick();
    push_op(4'd7);
    tick();
    push_op(4'd8);
    sb.push_back(6'b010010);
    check("gap_eval_no_valid", 32'(bus.out_valid), 0);
    tick();
    check("gap_latency_valid", 32'(bus.out_valid), 1);
    take_result("gap_result");

    // Fault injection on 4,4,4: adder reports 13 instead of 12.
    fault = 1'b1;
    send_triple(4'd4, 4'd4, 4'd4, 6'd13);
    wait_out_valid();
    check("fault_err_set", 32'(bus.err), 1);
    take_result("fault_result");
    fault = 1'b0;
    send_triple(4'd1, 4'd2, 4'd3, 6'd6);
    take_result("post_fault_1");
    check("err_sticky_1", 32'(bus.err), 1);
    send_triple(4'd3, 4'd3, 4'd3, 6'd9);
    take_result("post_fault_2");
    check("err_sticky_2", 32'(bus.err), 1);
    do_reset();
    exp_count = 8'd0;
    check("err_cleared", 32'(bus.err), 0);

    // Reset after two operands discards them.
    push_op(4'd9);
    push_op(4'd9);
    do_reset();
    check_reset_state();
    send_triple(4'd2, 4'd2, 4'd2, 6'b000110);
    take_result("no_stale_result");

    // Wrap triple_count: 255 more triples after the 2,2,2 one.
    for (int i = 0; i < 255; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      send_triple(ra, rb, rc, 6'(ra) + 6'(rb) + 6'(rc));
      take_result("wrap_result");
    end
    check("count_wrapped", 32'(bus.triple_count), 0);
    check("wrap_err", 32'(bus.err), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
